// File: rtl/cam_sensor_emulator.sv
// cam_sensor_emulator: MT9V034-style parallel camera output generator with programmable timing and test patterns.
// Optional CAM_EMU_FRAME_CNT_EN adds frame_cnt_o and stamps pixel (0,0) with the completed-frame count.
module cam_sensor_emulator #(
    parameter int H_ACTIVE = 752,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 94,
    parameter int V_BLANK  = 45,
    parameter int FV_LEAD  = 1,
    parameter int FV_TRAIL = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] pat_i,
    output logic       cam_frame_valid_o,
    output logic       cam_line_valid_o,
    output logic [9:0] cam_data_o,
    output logic       frame_done_o,
`ifdef CAM_EMU_FRAME_CNT_EN
    output logic [15:0] frame_cnt_o,
`endif
    output logic       busy_o
);
    localparam int PMAX = (FV_LEAD > H_BLANK ? FV_LEAD : H_BLANK) > (FV_TRAIL > V_BLANK ? FV_TRAIL : V_BLANK)
                        ? (FV_LEAD > H_BLANK ? FV_LEAD : H_BLANK) : (FV_TRAIL > V_BLANK ? FV_TRAIL : V_BLANK);
    localparam int PW = $clog2(PMAX + 1);
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int RW = $clog2(V_ACTIVE + 1);
    localparam logic [PW-1:0] LEAD_L = PW'(FV_LEAD - 1);
    localparam logic [PW-1:0] HB_L   = PW'(H_BLANK - 1);
    localparam logic [PW-1:0] TR_L   = PW'(FV_TRAIL > 0 ? FV_TRAIL - 1 : 0);
    localparam logic [PW-1:0] VB_L   = PW'(V_BLANK - 1);
    localparam logic [CW-1:0] HA_L   = CW'(H_ACTIVE - 1);
    localparam logic [RW-1:0] VA_L   = RW'(V_ACTIVE - 1);

    typedef enum logic [2:0] {IDLE, LEAD, LINE, HBLANK, TRAIL, VBLANK} state_t;

    state_t        state_q;
    logic [PW-1:0] cnt_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [1:0]    pat_q;
    logic          fv_q, lv_q, done_q, busy_q;
    logic [9:0]    data_q;
    logic          start;

`ifdef CAM_EMU_FRAME_CNT_EN
    logic [15:0] fcnt_q;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) fcnt_q <= '0;
        else if (done_q) fcnt_q <= fcnt_q + 16'd1;
    assign frame_cnt_o = fcnt_q;
`endif

    function automatic logic [9:0] pix(input logic [RW-1:0] r, input logic [CW-1:0] c);
        logic [7:0] g;
        g = 8'((32'(r) + 1) * 10 + 32'(c) + 1);
`ifdef CAM_EMU_FRAME_CNT_EN
        if (r == '0 && c == '0) return {fcnt_q[7:0], 2'b00};
`endif
        return pat_q == 2'd0 ? 10'(c) : pat_q == 2'd1 ? {g, 2'b00} : pat_q == 2'd2 ? 10'h3FF : {10{r[0] ^ c[0]}};
    endfunction

    // A new frame begins from IDLE or straight out of the last VBLANK cycle
    assign start = en_i && (state_q == IDLE || (state_q == VBLANK && cnt_q == VB_L));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pat_q   <= '0;
            fv_q    <= 1'b0;
            lv_q    <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            lv_q   <= 1'b0;
            data_q <= '0;
            done_q <= 1'b0;
            if (start) begin
                state_q <= LEAD;
                cnt_q   <= '0;
                col_q   <= '0;
                row_q   <= '0;
                pat_q   <= pat_i;
                fv_q    <= 1'b1;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    LEAD, HBLANK:
                        if (cnt_q == (state_q == LEAD ? LEAD_L : HB_L)) begin
                            state_q <= LINE;
                            col_q   <= '0;
                            lv_q    <= 1'b1;
                            data_q  <= pix(row_q, '0);
                        end else cnt_q <= cnt_q + 1'b1;
                    LINE:
                        if (col_q == HA_L) begin
                            cnt_q <= '0;
                            if (row_q != VA_L) begin
                                state_q <= HBLANK;
                                row_q   <= row_q + 1'b1;
                            end else if (FV_TRAIL > 0) state_q <= TRAIL;
                            else begin
                                state_q <= VBLANK;
                                fv_q    <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            col_q  <= col_q + 1'b1;
                            lv_q   <= 1'b1;
                            data_q <= pix(row_q, col_q + 1'b1);
                        end
                    TRAIL:
                        if (cnt_q == TR_L) begin
                            state_q <= VBLANK;
                            cnt_q   <= '0;
                            fv_q    <= 1'b0;
                            done_q  <= 1'b1;
                        end else cnt_q <= cnt_q + 1'b1;
                    VBLANK:
                        if (cnt_q == VB_L) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else cnt_q <= cnt_q + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign cam_frame_valid_o = fv_q;
    assign cam_line_valid_o  = lv_q;
    assign cam_data_o        = data_q;
    assign frame_done_o      = done_q;
    assign busy_o            = busy_q;
endmodule

// File: tb/tb_cam_sensor_emulator.sv
// tb_cam_sensor_emulator: directed and random stimulus against a frame-position reference model.
module tb_cam_sensor_emulator;
    localparam int HA = 2, VA = 3, HB = 1, VB = 1, LD = 1, TR = 0;
    localparam int LT = HA + HB;
    localparam int ACT = VA * HA + (VA - 1) * HB;
    localparam int DONE_T = LD + ACT + TR;
    localparam int PER = DONE_T + VB;
`ifdef CAM_EMU_FRAME_CNT_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, en = 1'b1;
    logic [1:0] pat = 2'd1;
    logic fv, lv, done, busy;
    logic [9:0] data;
    logic [15:0] fcnt;
    int ncmp = 0, nfail = 0, cyc = 0;
    bit chk_on = 1'b0;
    logic [9:0] cap[$];
    int ndone;

    cam_sensor_emulator #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB), .FV_LEAD(LD), .FV_TRAIL(TR)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .pat_i(pat),
        .cam_frame_valid_o(fv), .cam_line_valid_o(lv), .cam_data_o(data), .frame_done_o(done),
`ifdef CAM_EMU_FRAME_CNT_EN
        .frame_cnt_o(fcnt),
`endif
        .busy_o(busy));
`ifndef CAM_EMU_FRAME_CNT_EN
    assign fcnt = 16'd0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: a frame is just a position t in 0..PER-1; outputs are derived arithmetically from t
    bit m_run;
    int m_t;
    logic [1:0] m_pat;
    logic [15:0] m_fcnt;
    always @(posedge clk or posedge rst)
        if (rst) begin
            m_run <= 1'b0; m_t <= 0; m_pat <= 2'd0; m_fcnt <= 16'd0;
        end else begin
            if (m_run && m_t == DONE_T) m_fcnt <= m_fcnt + 16'd1;
            if (!m_run || m_t == PER - 1) begin
                m_run <= en; m_t <= 0;
                if (en) m_pat <= pat;
            end else m_t <= m_t + 1;
        end

    function automatic int pv(input int p, input int r, input int c, input int fc);
        if (FC && r == 0 && c == 0) return (fc % 256) * 4;
        case (p)
            0: return c % 1024;
            1: return (((r + 1) * 10 + c + 1) % 256) * 4;
            2: return 1023;
            default: return ((r ^ c) & 1) ? 1023 : 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (chk_on) begin
        int u, e_d;
        bit e_fv, e_lv;
        e_fv = m_run && m_t < DONE_T;
        e_lv = 1'b0; e_d = 0;
        if (m_run && m_t >= LD && m_t < LD + ACT) begin
            u = m_t - LD;
            if (u % LT < HA) begin
                e_lv = 1'b1;
                e_d = pv(int'(m_pat), u / LT, u % LT, int'(m_fcnt));
            end
        end
        chk("fv", 32'(fv), 32'(e_fv));
        chk("lv", 32'(lv), 32'(e_lv));
        chk("data", 32'(data), e_d);
        chk("done", 32'(done), 32'(m_run && m_t == DONE_T));
        chk("busy", 32'(busy), 32'(m_run));
        if (FC) chk("frame_cnt", 32'(fcnt), 32'(m_fcnt));
    end

    task automatic wait_fv(input logic val, input string tag);
        int n = 0;
        while (fv !== val && n < 40) begin @(negedge clk); n++; end
        chk(tag, 32'(fv), 32'(val));
    endtask

    task automatic collect_frame(input int sw_at, input logic [1:0] sw_pat);
        cap.delete();
        ndone = 0;
        for (int i = 0; i < PER; i++) begin
            if (i == sw_at) pat = sw_pat;
            if (lv) cap.push_back(data);
            if (done) ndone++;
            @(negedge clk);
        end
    endtask

    task automatic chk_list(input string tag, input int e0, input int e1, input int e2, input int e3, input int e4, input int e5);
        int e[6];
        e = '{e0, e1, e2, e3, e4, e5};
        chk({tag, "_len"}, cap.size(), 6);
        for (int i = FC ? 1 : 0; i < 6 && i < cap.size(); i++) chk(tag, 32'(cap[i]), e[i]);
    endtask

    initial begin
        int r1, n;
        // reset held with EN high
        repeat (3) begin
            @(negedge clk);
            chk("rst_fv", 32'(fv), 0); chk("rst_lv", 32'(lv), 0);
            chk("rst_data", 32'(data), 0); chk("rst_busy", 32'(busy), 0);
        end
        chk_on = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("start_fv", 32'(fv), 1); chk("start_busy", 32'(busy), 1);
        r1 = cyc;
        @(negedge clk);
        // grid pattern frame, then period check
        collect_frame(-1, 2'd0);
        chk_list("grid", 44, 48, 84, 88, 124, 128);
        chk("grid_done", ndone, 1);
        chk("period", cyc - r1, PER);
        chk("period_fv", 32'(fv), 1);
        // EN dropped during row 1
        repeat (4) @(negedge clk);
        en = 1'b0;
        n = 0;
        while (busy && n < 30) begin @(negedge clk); n++; end
        chk("stop_busy", 32'(busy), 0);
        repeat (5) begin @(negedge clk); chk("idle_fv", 32'(fv), 0); end
        // pattern change mid-frame takes effect next frame
        pat = 2'd0; en = 1'b1;
        wait_fv(1'b1, "ramp_rise");
        collect_frame(2, 2'd3);
        chk_list("ramp", 0, 1, 0, 1, 0, 1);
        collect_frame(-1, 2'd0);
        chk_list("checker", 0, 1023, 1023, 0, 0, 1023);
        // asynchronous reset during row 1
        pat = 2'd1;
        repeat (4) @(negedge clk);
        chk("pre_rst_lv", 32'(lv), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_fv", 32'(fv), 0); chk("arst_lv", 32'(lv), 0);
        chk("arst_data", 32'(data), 0); chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        wait_fv(1'b1, "restart_rise");
        @(negedge clk);
        chk("restart_lv", 32'(lv), 1);
        chk("restart_px", 32'(data), FC ? 0 : 44);
        // random EN/PAT
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            en = $urandom_range(0, 7) != 0;
            pat = 2'($urandom_range(0, 3));
        end
`ifdef CAM_EMU_FRAME_CNT_EN
        rst = 1'b1; en = 1'b1; pat = 2'd2;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        wait_fv(1'b1, "fc_rise");
        for (int k = 0; k < 3; k++) begin
            collect_frame(-1, 2'd2);
            chk("fc_px00", 32'(cap.size() > 0 ? cap[0] : 10'h155), 4 * k);
            for (int i = 1; i < cap.size(); i++) chk("fc_px", 32'(cap[i]), 1023);
        end
        chk("fc_count", 32'(fcnt), 3);
`endif
        @(negedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
